// File: rtl/ow_pkg.sv
// Shared 1-Wire definitions: slave state encoding, ROM-less command codes and
// default bus timing (clk cycles at 100 MHz) used by both master and slave.
package ow_pkg;

  typedef logic [2:0] ow_state_t;

  localparam ow_state_t ST_IDLE    = 3'd0;
  localparam ow_state_t ST_PD_DLY  = 3'd1;
  localparam ow_state_t ST_PD_DRV  = 3'd2;
  localparam ow_state_t ST_CMD     = 3'd3;
  localparam ow_state_t ST_WR_BYTE = 3'd4;
  localparam ow_state_t ST_RD_BYTE = 3'd5;

  localparam logic [7:0] OW_CMD_WRITE = 8'h4E;
  localparam logic [7:0] OW_CMD_READ  = 8'hBE;

  localparam int OW_RST_MIN = 48000;
  localparam int OW_PD_WAIT = 3000;
  localparam int OW_PD_LEN  = 12000;
  localparam int OW_SAMPLE  = 1500;
  localparam int OW_DRV_LEN = 3000;
  localparam int OW_CNT_W   = 16;

endpackage

// File: rtl/ow_slave_if.sv
// Bus-side and byte-side signals of the 1-Wire slave, grouped for port passing.
interface ow_slave_if;
  logic       dq_i;
  logic       dq_pull_low;
  logic [7:0] tx_byte;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       busy;

  modport slave  (input dq_i, tx_byte, output dq_pull_low, rx_byte, rx_valid, busy);
  modport master (output dq_i, tx_byte, input dq_pull_low, rx_byte, rx_valid, busy);
endinterface

// File: rtl/ow_sync_edge.sv
// Two-flop synchroniser for the asynchronous bus level plus a third flop that
// yields single-cycle fall/rise strobes on the synchronised level.
module ow_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic lvl,
  output logic fall,
  output logic rise
);
  logic [2:0] sync_q;

  // Reset to the idle (pulled-up) level so leaving reset never fakes a fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 3'b111;
    else       sync_q <= {sync_q[1:0], d_i};
  end

  assign lvl  = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];
  assign rise = ~sync_q[2] & sync_q[1];
endmodule

// File: rtl/ow_slave.sv
// 1-Wire slave: detects bus reset, answers with presence, decodes one command
// byte and then receives (0x4E) or returns (0xBE) a single data byte.
module ow_slave
  import ow_pkg::*;
#(
  parameter int RST_MIN = OW_RST_MIN,
  parameter int PD_WAIT = OW_PD_WAIT,
  parameter int PD_LEN  = OW_PD_LEN,
  parameter int SAMPLE  = OW_SAMPLE,
  parameter int DRV_LEN = OW_DRV_LEN,
  parameter int CNT_W   = OW_CNT_W
) (
  input logic       clk,
  input logic       reset,
  ow_slave_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] RST_MIN_C   = CNT_W'(RST_MIN);
  localparam logic [CNT_W-1:0] PD_WAIT_END = CNT_W'(PD_WAIT - 1);
  localparam logic [CNT_W-1:0] PD_LEN_END  = CNT_W'(PD_LEN - 1);
  localparam logic [CNT_W-1:0] SAMPLE_C    = CNT_W'(SAMPLE);
  localparam logic [CNT_W-1:0] DRV_END     = CNT_W'(DRV_LEN - 1);

  logic             lvl, fall, rise;
  ow_state_t        state_q, state_d;
  logic [CNT_W-1:0] low_cnt_q, low_cnt_d, timer_q, timer_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             slot_q, slot_d;
  logic [7:0]       shreg_q, shreg_d, rx_byte_q, rx_byte_d;
  logic             rx_valid_q, rx_valid_d, pull_q, pull_d;
  logic [7:0]       shifted;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  ow_sync_edge u_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (bus.dq_i),
    .lvl  (lvl),
    .fall (fall),
    .rise (rise)
  );

  assign shifted = {lvl, shreg_q[7:1]};

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path can infer a latch.
    state_d    = state_q;
    low_cnt_d  = lvl ? '0 : sat_inc(low_cnt_q);
    timer_d    = sat_inc(timer_q);
    bit_cnt_d  = bit_cnt_q;
    slot_d     = slot_q;
    shreg_d    = shreg_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    pull_d     = pull_q;

    // A long-enough low ending on a rise aborts anything in flight.
    if (rise && (low_cnt_q >= RST_MIN_C)) begin
      state_d   = ST_PD_DLY;
      timer_d   = '0;
      pull_d    = 1'b0;
      slot_d    = 1'b0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        ST_PD_DLY: if (timer_q == PD_WAIT_END) begin
          state_d = ST_PD_DRV;
          timer_d = '0;
          pull_d  = 1'b1;
        end
        ST_PD_DRV: if (timer_q == PD_LEN_END) begin
          state_d   = ST_CMD;
          pull_d    = 1'b0;
          bit_cnt_d = '0;
          slot_d    = 1'b0;
        end
        ST_CMD, ST_WR_BYTE: begin
          if (fall) begin
            timer_d = '0;
            slot_d  = 1'b1;
          end else if (slot_q && (timer_q == SAMPLE_C)) begin
            slot_d    = 1'b0;
            shreg_d   = shifted;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == ST_WR_BYTE) begin
                rx_byte_d  = shifted;
                rx_valid_d = 1'b1;
                state_d    = ST_IDLE;
              end else if (shifted == OW_CMD_WRITE) begin
                state_d = ST_WR_BYTE;
              end else if (shifted == OW_CMD_READ) begin
                state_d = ST_RD_BYTE;
                shreg_d = bus.tx_byte;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end
        end
        ST_RD_BYTE: begin
          if (fall) begin
            timer_d = '0;
            slot_d  = 1'b1;
            pull_d  = ~shreg_q[0];
          end else if (slot_q && (timer_q == DRV_END)) begin
            slot_d    = 1'b0;
            pull_d    = 1'b0;
            shreg_d   = {1'b0, shreg_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      low_cnt_q  <= '0;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      slot_q     <= 1'b0;
      shreg_q    <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      pull_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      low_cnt_q  <= low_cnt_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      slot_q     <= slot_d;
      shreg_q    <= shreg_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      pull_q     <= pull_d;
    end
  end

  assign bus.dq_pull_low = pull_q;
  assign bus.rx_byte     = rx_byte_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_ow_slave.sv
// Self-checking bench for ow_slave: a behavioural 1-Wire master on a wired-AND
// bus, with timing scaled down so reset/presence sequences stay short.
`timescale 1ns/1ps
module tb_ow_slave;
  import ow_pkg::*;

  localparam int RST_MIN = 480;
  localparam int PD_WAIT = 30;
  localparam int PD_LEN  = 120;
  localparam int SAMPLE  = 15;
  localparam int DRV_LEN = 30;
  localparam int CNT_W   = 10;
  localparam int SLOT    = 70;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic m_low = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ow_slave_if ifc ();
  assign ifc.dq_i = ~(m_low | ifc.dq_pull_low);

  ow_slave #(
    .RST_MIN(RST_MIN), .PD_WAIT(PD_WAIT), .PD_LEN(PD_LEN),
    .SAMPLE(SAMPLE), .DRV_LEN(DRV_LEN), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  // Bus/output monitor
  int      rxv_cnt = 0;
  int      rxv_double = 0;
  int      pull_cnt = 0;
  logic    prev_rxv = 1'b0;
  logic    prev_busy = 1'b0;
  logic    busy_at_rxv = 1'b1;
  logic    busy_before_rxv = 1'b0;
  realtime t_pull_fall = -1.0;

  always @(negedge clk) begin
    if (ifc.rx_valid) begin
      rxv_cnt++;
      busy_at_rxv = ifc.busy;
      busy_before_rxv = prev_busy;
      if (prev_rxv) rxv_double++;
    end
    if (ifc.dq_pull_low) pull_cnt++;
    prev_rxv  = ifc.rx_valid;
    prev_busy = ifc.busy;
  end

  always @(negedge ifc.dq_pull_low) t_pull_fall = $realtime;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- master-side primitives ----------------
  task automatic master_reset(input int len);
    m_low = 1'b1;
    repeat (len) @(negedge clk);
    m_low = 1'b0;
  endtask

  task automatic expect_presence(input bit exp, input string name);
    int n;
    int h;
    bit seen;
    n = 0;
    h = 0;
    seen = 1'b0;
    while (n < PD_WAIT + PD_LEN + 20 && !seen) begin
      @(posedge clk); #1;
      n++;
      if (ifc.dq_pull_low) seen = 1'b1;
    end
    checks++;
    if (seen !== exp) begin
      errors++;
      $display("FAIL %s presence: got %0d expected %0d", name, seen, exp);
    end
    if (seen && exp) begin
      checks++;
      if (n != PD_WAIT + 3) begin
        errors++;
        $display("FAIL %s presence delay: got %0d expected %0d", name, n, PD_WAIT + 3);
      end
      h = 1;
      while (h < PD_LEN + 20) begin
        @(posedge clk); #1;
        if (!ifc.dq_pull_low) break;
        h++;
      end
      checks++;
      if (h != PD_LEN) begin
        errors++;
        $display("FAIL %s presence length: got %0d expected %0d", name, h, PD_LEN);
      end
    end
    @(negedge clk);
    repeat (10) @(negedge clk);
  endtask

  task automatic write_bit(input logic b);
    int low;
    low = b ? 5 : 50;
    m_low = 1'b1;
    repeat (low) @(negedge clk);
    m_low = 1'b0;
    repeat (SLOT - low) @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) write_bit(v[i]);
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b1;
    repeat (3) @(negedge clk);
    m_low = 1'b0;
    repeat (SAMPLE - 3) @(negedge clk);
    b = ifc.dq_i;
    repeat (SLOT - SAMPLE) @(negedge clk);
  endtask

  task automatic reset_and_presence(input string name);
    master_reset(RST_MIN);
    expect_presence(1'b1, name);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int len;
    checks++;
    if (ifc.dq_pull_low !== 1'b0) begin errors++; $display("FAIL reset pull: got %b expected 0", ifc.dq_pull_low); end
    checks++;
    if (ifc.rx_byte !== 8'h00) begin errors++; $display("FAIL reset rx_byte: got %h expected 00", ifc.rx_byte); end
    checks++;
    if (ifc.rx_valid !== 1'b0) begin errors++; $display("FAIL reset rx_valid: got %b expected 0", ifc.rx_valid); end
    checks++;
    if (ifc.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", ifc.busy); end

    master_reset(RST_MIN - 1);
    expect_presence(RST_MIN - 1 >= RST_MIN, "short_by_one");
    len = $urandom_range(100, RST_MIN - 1);
    master_reset(len);
    expect_presence(len >= RST_MIN, "short_random");
    master_reset(RST_MIN);
    expect_presence(1'b1, "exact_min");
    len = $urandom_range(RST_MIN, 900);
    master_reset(len);
    expect_presence(len >= RST_MIN, "long_random");
    master_reset(1100);
    expect_presence(1'b1, "saturate");
  endtask

  task automatic test_write();
    logic [7:0] data;
    int rx0;
    for (int k = 0; k < 3; k++) begin
      data = (k == 0) ? 8'hA5 : 8'($urandom);
      reset_and_presence("write");
      write_byte(OW_CMD_WRITE);
      rx0 = rxv_cnt;
      write_byte(data);
      checks++;
      if (rxv_cnt - rx0 != 1) begin errors++; $display("FAIL write rx_valid count: got %0d expected 1", rxv_cnt - rx0); end
      checks++;
      if (ifc.rx_byte !== data) begin errors++; $display("FAIL write rx_byte: got %h expected %h", ifc.rx_byte, data); end
      checks++;
      if (busy_at_rxv !== 1'b0 || busy_before_rxv !== 1'b1) begin
        errors++;
        $display("FAIL write busy edge: got before=%b at=%b expected before=1 at=0", busy_before_rxv, busy_at_rxv);
      end
    end
  endtask

  task automatic test_read();
    logic [7:0] tx;
    logic [7:0] got;
    logic b;
    for (int k = 0; k < 3; k++) begin
      tx = (k == 0) ? 8'hAA : 8'($urandom);
      ifc.tx_byte = tx;
      reset_and_presence("read");
      write_byte(OW_CMD_READ);
      ifc.tx_byte = ~tx;
      for (int i = 0; i < 8; i++) begin
        read_bit(b);
        got[i] = b;
      end
      checks++;
      if (got !== tx) begin errors++; $display("FAIL read byte: got %h expected %h", got, tx); end
      checks++;
      if (ifc.busy !== 1'b0) begin errors++; $display("FAIL read busy after: got %b expected 0", ifc.busy); end
    end
  endtask

  task automatic test_bad_cmd();
    logic [7:0] cmd;
    logic [7:0] got;
    logic b;
    int p0;
    int rx0;
    for (int k = 0; k < 2; k++) begin
      cmd = (k == 0) ? 8'h12 : 8'($urandom);
      if (cmd == OW_CMD_WRITE || cmd == OW_CMD_READ) cmd = 8'h12;
      ifc.tx_byte = 8'h00;
      reset_and_presence("bad_cmd");
      write_byte(cmd);
      checks++;
      if (ifc.busy !== 1'b0) begin errors++; $display("FAIL bad_cmd busy: got %b expected 0", ifc.busy); end
      p0 = pull_cnt;
      for (int i = 0; i < 8; i++) begin
        read_bit(b);
        got[i] = b;
      end
      checks++;
      if (got !== 8'hFF || pull_cnt != p0) begin
        errors++;
        $display("FAIL bad_cmd ignore: got bits=%h drive=%0d expected ff 0", got, pull_cnt - p0);
      end
      rx0 = rxv_cnt;
      write_byte(OW_CMD_WRITE);
      write_byte(8'h3C);
      checks++;
      if (rxv_cnt != rx0) begin errors++; $display("FAIL bad_cmd write ignored: got %0d expected 0", rxv_cnt - rx0); end
    end
    reset_and_presence("bad_cmd_recover");
  endtask

  task automatic test_abort();
    logic [7:0] data;
    int rx0;
    data = 8'($urandom);
    write_byte(OW_CMD_WRITE);
    rx0 = rxv_cnt;
    for (int i = 0; i < 4; i++) write_bit(data[i]);
    reset_and_presence("abort");
    checks++;
    if (rxv_cnt != rx0) begin errors++; $display("FAIL abort rx_valid: got %0d expected 0", rxv_cnt - rx0); end
    data = 8'($urandom);
    write_byte(OW_CMD_WRITE);
    write_byte(data);
    checks++;
    if (rxv_cnt - rx0 != 1 || ifc.rx_byte !== data) begin
      errors++;
      $display("FAIL abort fresh write: got cnt=%0d byte=%h expected 1 %h", rxv_cnt - rx0, ifc.rx_byte, data);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] tx;
    realtime t_rst;
    logic [7:0] data;
    tx = 8'($urandom) & 8'hFE;
    ifc.tx_byte = tx;
    reset_and_presence("async");
    write_byte(OW_CMD_READ);
    m_low = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (ifc.dq_pull_low !== 1'b1) begin errors++; $display("FAIL async drive active: got %b expected 1", ifc.dq_pull_low); end
    #2;
    reset = 1'b1;
    t_rst = $realtime;
    #1;
    checks++;
    if (t_pull_fall != t_rst) begin errors++; $display("FAIL async release time: got %0t expected %0t", t_pull_fall, t_rst); end
    checks++;
    if ({ifc.dq_pull_low, ifc.rx_valid, ifc.busy} !== 3'b000 || ifc.rx_byte !== 8'h00) begin
      errors++;
      $display("FAIL async outputs: got pull=%b valid=%b busy=%b rx=%h expected 0 0 0 00",
               ifc.dq_pull_low, ifc.rx_valid, ifc.busy, ifc.rx_byte);
    end
    m_low = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    data = 8'($urandom);
    reset_and_presence("async_recover");
    write_byte(OW_CMD_WRITE);
    write_byte(data);
    checks++;
    if (ifc.rx_byte !== data) begin errors++; $display("FAIL async recover rx_byte: got %h expected %h", ifc.rx_byte, data); end
  endtask

  initial begin
    ifc.tx_byte = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_bad_cmd();
    test_abort();
    test_async_reset();
    checks++;
    if (rxv_double != 0) begin errors++; $display("FAIL rx_valid consecutive: got %0d expected 0", rxv_double); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ow_slave.md
# ow_slave

Synthesizable 1-Wire slave endpoint that sits on the bus directly downstream of the 1-Wire master and answers its transactions. It detects reset pulses, returns a presence pulse, and receives an 8-bit command. It then either receives one data byte from the master or returns one data byte to it. It replaces behavioural bus stimulus with real RTL and gives the master a bit-accurate partner.

## Interface
Parameters (all in `clk` cycles, 100 MHz / 10 ns):
- `RST_MIN`, 48000: minimum low time recognised as bus reset (480 µs).
- `PD_WAIT`, 3000: delay from reset release to presence start (30 µs).
- `PD_LEN`, 12000: presence pulse length (120 µs).
- `SAMPLE`, 1500: falling edge → sample point for master write slots (15 µs).
- `DRV_LEN`, 3000: low hold for a transmitted 0 bit (30 µs).
- `CNT_W`, 16: slot/timer counter width; must hold `RST_MIN`.

Ports:
- `clk`, in, 1: system clock. One clock domain.
- `reset`, in, 1: asynchronous, active-high reset.
- `dq_i`, in, 1: resolved bus level. Asynchronous; pulled up when idle.
- `dq_pull_low`, out, 1: 1 = drive bus to 0, 0 = release (high-Z). The top level does `assign port = dq_pull_low ? 1'b0 : 1'bz`.
- `tx_byte`, in, 8: byte returned on a READ command; latched at command decode.
- `rx_byte`, out, 8: last byte received by a WRITE command.
- `rx_valid`, out, 1: one-cycle pulse when `rx_byte` updates.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- Input path: 2-flop synchroniser on `dq_i`, then a third flop for edge detect (`fall`, `rise`). All timing is referenced to synchronised edges.
- States: IDLE, PD_DLY, PD_DRV, CMD, WR_BYTE, RD_BYTE.
- Reset detector runs in every state:
  - A low counter counts while the synchronised bus is low and clears on high.
  - On `rise` with count ≥ `RST_MIN` → PD_DLY and timer cleared, from any state.
  - An in-progress byte is discarded; `rx_valid` does not fire.
- PD_DLY: wait `PD_WAIT` cycles → PD_DRV.
- PD_DRV: `dq_pull_low`=1 for `PD_LEN` cycles, then release; bit counter = 0 → CMD.
- Receive slot (CMD, WR_BYTE):
  - Each `fall` restarts the slot timer.
  - At timer = `SAMPLE`, shift the synchronised bus level into the shift register MSB. Data is LSB first, so after 8 bits shreg[0] is the first bit.
  - One sample per slot; further edges are ignored until the next `fall`.
- CMD decode after 8 bits:
  - 0x4E → WR_BYTE.
  - 0xBE → latch `tx_byte` into the shift register → RD_BYTE.
  - Anything else → IDLE, and the slave ignores the bus until the next reset.
- WR_BYTE: after 8 bits, `rx_byte` ← shreg and `rx_valid` pulses in the same cycle → IDLE.
- RD_BYTE, per master `fall`:
  - Current bit 0 → `dq_pull_low`=1 for `DRV_LEN` cycles from the synchronised `fall`.
  - Current bit 1 → stay released.
  - Shift right at the end of the slot (timer = `DRV_LEN`). After the 8th slot → IDLE.
- A `fall` caused by the slave's own drive is not possible: the slave drives only after a master `fall` and while the bus is already low.

## Timing
- Reset values: `dq_pull_low`=0, `rx_byte`=8'h00, `rx_valid`=0, `busy`=0, state IDLE, all counters 0.
- Input latency: 2 cycles from the `dq_i` edge to the synchronised edge. All parameter counts are measured from the synchronised edge.
- Presence: `dq_pull_low` rises `PD_WAIT`+3 cycles after the bus release and stays high exactly `PD_LEN` cycles.
- Counters saturate; the low counter must not wrap during a long-held bus.
- The reset detector has priority over slot handling in the same cycle.
- Asserting `reset` mid-drive releases `dq_pull_low` immediately (asynchronously).
- `rx_valid` is registered and is never high for two consecutive cycles.

## Structure
- Package `ow_pkg`: state enum, command constants `OW_CMD_WRITE`=8'h4E and `OW_CMD_READ`=8'hBE, default timing constants shared with the master.
- Sub-module `ow_sync_edge`: synchroniser plus edge detect, outputs `lvl`, `fall`, `rise`.
- All other logic is flat in `ow_slave`.

## Test plan
- 480 µs low then release → `dq_pull_low` high from 30 µs after release for 120 µs. A 400 µs low → no presence.
- Reset, presence, master writes 0x4E then 0xA5 → `rx_byte`=0xA5 with one `rx_valid` pulse; `busy` falls the same cycle.
- Reset, presence, 0xBE with `tx_byte`=0xAA → master samples at 15 µs and reads bits 0,1,0,1,0,1,0,1 (LSB first) = 0xAA.
- Command 0x12 → IDLE. Following slots produce no drive until a new 480 µs reset, which yields presence again.
- 480 µs reset after 4 bits of a WR_BYTE → no `rx_valid`, new presence, a fresh command is accepted.
- Assert `reset` during a 0-bit drive in RD_BYTE → `dq_pull_low`=0 within the same time step; all outputs at reset values.
